// File: rtl/conv_window_slider_pkg.sv
// -----------------------------------------------------------------------------
// conv_window_slider_pkg : shared sizes and FSM encoding for the window slider
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package conv_window_slider_pkg;
  localparam int DEF_IMG_W = 416;
  localparam int DEF_PIX_W = 8;
  localparam int KSIZE     = 3;
  localparam int COL_W     = 9;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SLIDE = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/conv_window_slider_if.sv
// -----------------------------------------------------------------------------
// conv_window_slider_if : row-triple input bus and 3x3x3 window output bus
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface conv_window_slider_rows_if import conv_window_slider_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int PIX_W = DEF_PIX_W
) ();
  localparam int ROW_W = (IMG_W + 2) * PIX_W;

  logic             rows_valid;
  logic             rows_ready;
  logic [ROW_W-1:0] R_row0, R_row1, R_row2;
  logic [ROW_W-1:0] G_row0, G_row1, G_row2;
  logic [ROW_W-1:0] B_row0, B_row1, B_row2;

  modport master (
    output rows_valid, R_row0, R_row1, R_row2, G_row0, G_row1, G_row2,
           B_row0, B_row1, B_row2,
    input  rows_ready
  );
  modport slave (
    input  rows_valid, R_row0, R_row1, R_row2, G_row0, G_row1, G_row2,
           B_row0, B_row1, B_row2,
    output rows_ready
  );
endinterface

interface conv_window_slider_win_if import conv_window_slider_pkg::*; #(
  parameter int PIX_W = DEF_PIX_W
) ();
  logic               win_valid;
  logic               win_ready;
  logic [9*PIX_W-1:0] win_R;
  logic [9*PIX_W-1:0] win_G;
  logic [9*PIX_W-1:0] win_B;
  logic [COL_W-1:0]   win_col;
  logic               win_last;

  modport master (
    output win_valid, win_R, win_G, win_B, win_col, win_last,
    input  win_ready
  );
  modport slave (
    input  win_valid, win_R, win_G, win_B, win_col, win_last,
    output win_ready
  );
endinterface

`default_nettype wire

// File: rtl/conv_window_slider_row_tap3.sv
// -----------------------------------------------------------------------------
// conv_window_slider_row_tap3 : picks padded pixels col, col+1, col+2 of one row
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module conv_window_slider_row_tap3 import conv_window_slider_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int PIX_W = DEF_PIX_W
) (
  input  wire [(IMG_W+2)*PIX_W-1:0] row,
  input  wire [COL_W-1:0]           col,
  output logic [3*PIX_W-1:0]        taps
);
  localparam int ROW_W = (IMG_W + 2) * PIX_W;
  localparam int IDX_W = $clog2(ROW_W);

  logic [IDX_W-1:0] w_bit_idx;

  assign w_bit_idx = IDX_W'(col) * IDX_W'(PIX_W);
  assign taps      = row[w_bit_idx +: 3*PIX_W];
endmodule

`default_nettype wire

// File: rtl/conv_window_slider.sv
// -----------------------------------------------------------------------------
// conv_window_slider : captures a padded RGB row triple and streams IMG_W 3x3 windows
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module conv_window_slider import conv_window_slider_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int PIX_W = DEF_PIX_W
) (
  input  wire                        clk,
  input  wire                        reset,
  conv_window_slider_rows_if.slave   rows,
  conv_window_slider_win_if.master   win,
  output logic                       busy
);
  localparam int               ROW_W    = (IMG_W + 2) * PIX_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  if (IMG_W + 1 > 512) begin : g_col_range_check
    $error("conv_window_slider: IMG_W+1 exceeds 9-bit column range");
  end

  state_t           r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             w_capture;
  logic             w_slide;

  logic [ROW_W-1:0] w_rows_in [KSIZE][KSIZE];
  logic [ROW_W-1:0] r_rows    [KSIZE][KSIZE];

  // [channel][row] with channel 0/1/2 = R/G/B
  assign w_rows_in[0][0] = rows.R_row0;
  assign w_rows_in[0][1] = rows.R_row1;
  assign w_rows_in[0][2] = rows.R_row2;
  assign w_rows_in[1][0] = rows.G_row0;
  assign w_rows_in[1][1] = rows.G_row1;
  assign w_rows_in[1][2] = rows.G_row2;
  assign w_rows_in[2][0] = rows.B_row0;
  assign w_rows_in[2][1] = rows.B_row1;
  assign w_rows_in[2][2] = rows.B_row2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_rows  <= '{default: '0};
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      if (w_capture) begin
        r_rows <= w_rows_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rows.rows_valid) begin
          w_capture   = 1'b1;
          w_col_nxt   = '0;
          w_state_nxt = ST_SLIDE;
        end
      end
      ST_SLIDE: begin
        if (win.win_ready) begin
          if (r_col == LAST_COL) begin
            w_col_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_col_nxt   = r_col + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Row r of a channel lands in bits [3*PIX_W*r +: 3*PIX_W], giving tap k = 3*r+c
  logic [KSIZE-1:0][KSIZE-1:0][KSIZE*PIX_W-1:0] w_taps;

  for (genvar ch = 0; ch < KSIZE; ch++) begin : g_ch
    for (genvar rw = 0; rw < KSIZE; rw++) begin : g_row
      conv_window_slider_row_tap3 #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
      ) u_tap (
        .row  (r_rows[ch][rw]),
        .col  (r_col),
        .taps (w_taps[ch][rw])
      );
    end
  end

  assign w_slide         = (r_state == ST_SLIDE);
  assign rows.rows_ready = (r_state == ST_IDLE);
  assign busy            = w_slide;
  assign win.win_valid   = w_slide;
  assign win.win_R       = w_slide ? w_taps[0] : '0;
  assign win.win_G       = w_slide ? w_taps[1] : '0;
  assign win.win_B       = w_slide ? w_taps[2] : '0;
  assign win.win_col     = w_slide ? r_col : '0;
  assign win.win_last    = w_slide && (r_col == LAST_COL);
endmodule

`default_nettype wire

// File: tb/tb_conv_window_slider.sv
// -----------------------------------------------------------------------------
// tb_conv_window_slider : directed self-checking bench for conv_window_slider
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_slider;
  import conv_window_slider_pkg::*;

  localparam int W   = DEF_IMG_W;
  localparam int PW  = DEF_PIX_W;
  localparam int PAD = W + 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_window_slider_rows_if #(.IMG_W(W), .PIX_W(PW)) rows_bus ();
  conv_window_slider_win_if  #(.PIX_W(PW))            win_bus ();

  conv_window_slider #(.IMG_W(W), .PIX_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .rows  (rows_bus.slave),
    .win   (win_bus.master),
    .busy  (busy)
  );

  // Pattern 0: ramp R, G=j^0x55, B=~j; 1: alternate triple; 2: zero-padded edges
  function automatic logic [7:0] pix(input int m, input int ch, input int r, input int j);
    int v;
    v = 0;
    case (m)
      0: case (ch)
           0: v = r * 100 + j;
           1: v = j ^ 'h55;
           default: v = ~j;
         endcase
      1: case (ch)
           0: v = r * 7 + 3 * j + 1;
           1: v = j * 5 + r;
           default: v = j + r * 9 + 77;
         endcase
      default: v = (j == 0 || j == PAD - 1) ? 0 : ((r * 37 + ch * 11 + j) % 255) + 1;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [9*PW-1:0] exp_win(input int m, input int ch, input int col);
    logic [9*PW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[PW*(3*r+c) +: PW] = pix(m, ch, r, col + c);
    return w;
  endfunction

  task automatic pack_rows(input int m);
    for (int j = 0; j < PAD; j++) begin
      rows_bus.R_row0[PW*j +: PW] = pix(m, 0, 0, j);
      rows_bus.R_row1[PW*j +: PW] = pix(m, 0, 1, j);
      rows_bus.R_row2[PW*j +: PW] = pix(m, 0, 2, j);
      rows_bus.G_row0[PW*j +: PW] = pix(m, 1, 0, j);
      rows_bus.G_row1[PW*j +: PW] = pix(m, 1, 1, j);
      rows_bus.G_row2[PW*j +: PW] = pix(m, 1, 2, j);
      rows_bus.B_row0[PW*j +: PW] = pix(m, 2, 0, j);
      rows_bus.B_row1[PW*j +: PW] = pix(m, 2, 1, j);
      rows_bus.B_row2[PW*j +: PW] = pix(m, 2, 2, j);
    end
  endtask

  task automatic test_reset();
    rows_bus.rows_valid = 1'b0;
    win_bus.win_ready   = 1'b0;
    pack_rows(0);
    repeat (2) @(negedge clk);
    checks++;
    if ({rows_bus.rows_ready, win_bus.win_valid, busy, win_bus.win_last} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/busy/last=%b required 1000",
               {rows_bus.rows_ready, win_bus.win_valid, busy, win_bus.win_last});
    end
    checks++;
    if ({win_bus.win_R, win_bus.win_G, win_bus.win_B, win_bus.win_col} !== '0) begin
      errors++;
      $display("FAIL reset_data: got col=%0d R=%h required all zero", win_bus.win_col, win_bus.win_R);
    end
    reset = 1'b1;
    @(negedge clk);
    rows_bus.rows_valid = 1'b1;
    win_bus.win_ready   = 1'b1;
    @(negedge clk);
    rows_bus.rows_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, win_bus.win_valid, win_bus.win_col} !== {2'b11, 9'd5}) begin
      errors++;
      $display("FAIL midrun_pre: got busy=%b vld=%b col=%0d required 1 1 5",
               busy, win_bus.win_valid, win_bus.win_col);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({rows_bus.rows_ready, win_bus.win_valid, busy, win_bus.win_last} !== 4'b1000) begin
      errors++;
      $display("FAIL midrun_reset_flags: got rdy/vld/busy/last=%b required 1000",
               {rows_bus.rows_ready, win_bus.win_valid, busy, win_bus.win_last});
    end
    checks++;
    if ({win_bus.win_R, win_bus.win_G, win_bus.win_B, win_bus.win_col} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_data: got col=%0d R=%h required all zero",
               win_bus.win_col, win_bus.win_R);
    end
    @(negedge clk);
    reset = 1'b1;
    win_bus.win_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rows_bus.rows_ready, win_bus.win_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release_idle: got rdy/vld/busy=%b required 100",
               {rows_bus.rows_ready, win_bus.win_valid, busy});
    end
  endtask

  task automatic test_count_last();
    logic [9*PW-1:0] c0, c415;
    int  n, lasts;
    bit  done, seen415;
    c0   = {8'd202, 8'd201, 8'd200, 8'd102, 8'd101, 8'd100, 8'd2, 8'd1, 8'd0};
    c415 = {8'd105, 8'd104, 8'd103, 8'd5, 8'd4, 8'd3, 8'd161, 8'd160, 8'd159};
    pack_rows(0);
    win_bus.win_ready   = 1'b1;
    rows_bus.rows_valid = 1'b1;
    @(negedge clk);
    rows_bus.rows_valid = 1'b0;
    checks++;
    if ({win_bus.win_valid, busy, rows_bus.rows_ready, win_bus.win_col} !== {3'b110, 9'd0}) begin
      errors++;
      $display("FAIL latency1: got vld/busy/rdy=%b col=%0d required 110 col 0",
               {win_bus.win_valid, busy, rows_bus.rows_ready}, win_bus.win_col);
    end
    checks++;
    if (win_bus.win_R !== c0) begin
      errors++;
      $display("FAIL ramp_col0: got %h required %h", win_bus.win_R, c0);
    end
    n = 0; lasts = 0; done = 1'b0; seen415 = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (win_bus.win_valid) begin
        if (win_bus.win_col == 9'd415) begin
          seen415 = 1'b1;
          checks++;
          if (win_bus.win_R !== c415) begin
            errors++;
            $display("FAIL ramp_col415: got %h required %h", win_bus.win_R, c415);
          end
        end
        checks++;
        if (win_bus.win_last !== (n == W - 1)) begin
          errors++;
          $display("FAIL last_flag: transfer %0d got last=%b required %b", n, win_bus.win_last, n == W - 1);
        end
        if (win_bus.win_last) lasts++;
        n++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done || !seen415 || n != W || lasts != 1) begin
      errors++;
      $display("FAIL transfer_count: got n=%0d lasts=%0d done=%b required n=%0d lasts=1 done=1",
               n, lasts, done, W);
    end
    checks++;
    if ({busy, rows_bus.rows_ready} !== 2'b01) begin
      errors++;
      $display("FAIL post_last_idle: got busy/rdy=%b required 01", {busy, rows_bus.rows_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [9*PW-1:0] pr, pg, pb;
    logic [8:0]      pc;
    bit              stalled;
    int              ex;
    pack_rows(0);
    win_bus.win_ready   = 1'b0;
    rows_bus.rows_valid = 1'b1;
    @(negedge clk);
    rows_bus.rows_valid = 1'b0;
    ex = 0; stalled = 1'b0; pr = '0; pg = '0; pb = '0; pc = '0;
    for (int cyc = 0; cyc < 5000 && ex < W; cyc++) begin
      checks++;
      if (win_bus.win_valid !== 1'b1 || win_bus.win_col !== 9'(ex) ||
          win_bus.win_R !== exp_win(0, 0, ex) || win_bus.win_G !== exp_win(0, 1, ex) ||
          win_bus.win_B !== exp_win(0, 2, ex) || win_bus.win_last !== (ex == W - 1)) begin
        errors++;
        $display("FAIL bp_window: got vld=%b col=%0d R=%h G=%h B=%h required col=%0d R=%h G=%h B=%h",
                 win_bus.win_valid, win_bus.win_col, win_bus.win_R, win_bus.win_G, win_bus.win_B,
                 ex, exp_win(0, 0, ex), exp_win(0, 1, ex), exp_win(0, 2, ex));
      end
      if (stalled) begin
        checks++;
        if ({win_bus.win_R, win_bus.win_G, win_bus.win_B, win_bus.win_col} !== {pr, pg, pb, pc}) begin
          errors++;
          $display("FAIL bp_stable: got col=%0d R=%h required col=%0d R=%h",
                   win_bus.win_col, win_bus.win_R, pc, pr);
        end
      end
      pr = win_bus.win_R; pg = win_bus.win_G; pb = win_bus.win_B; pc = win_bus.win_col;
      win_bus.win_ready = 1'($urandom_range(0, 1));
      stalled = !win_bus.win_ready;
      if (win_bus.win_ready) ex++;
      @(negedge clk);
    end
    checks++;
    if (ex != W || win_bus.win_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got transfers=%0d vld=%b required %0d vld=0", ex, win_bus.win_valid, W);
    end
  endtask

  task automatic test_no_recapture();
    int n, gap;
    pack_rows(0);
    win_bus.win_ready   = 1'b1;
    rows_bus.rows_valid = 1'b1;
    @(negedge clk);
    pack_rows(1);
    n = 0;
    for (int cyc = 0; cyc < 600 && win_bus.win_valid; cyc++) begin
      checks++;
      if (win_bus.win_col !== 9'(n) || win_bus.win_R !== exp_win(0, 0, n) ||
          win_bus.win_G !== exp_win(0, 1, n) || win_bus.win_B !== exp_win(0, 2, n)) begin
        errors++;
        $display("FAIL hold_valid_window: got col=%0d R=%h required col=%0d R=%h",
                 win_bus.win_col, win_bus.win_R, n, exp_win(0, 0, n));
      end
      n++;
      @(negedge clk);
    end
    gap = 0;
    while (!win_bus.win_valid && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    rows_bus.rows_valid = 1'b0;
    checks++;
    if (n != W || gap != 1) begin
      errors++;
      $display("FAIL bubble: got transfers=%0d bubble=%0d required %0d and 1", n, gap, W);
    end
    checks++;
    if (win_bus.win_col !== 9'd0 || win_bus.win_R !== exp_win(1, 0, 0) ||
        win_bus.win_G !== exp_win(1, 1, 0) || win_bus.win_B !== exp_win(1, 2, 0)) begin
      errors++;
      $display("FAIL second_triple: got col=%0d R=%h required col=0 R=%h",
               win_bus.win_col, win_bus.win_R, exp_win(1, 0, 0));
    end
    for (int cyc = 0; cyc < 600 && win_bus.win_valid; cyc++) @(negedge clk);
    checks++;
    if ({busy, rows_bus.rows_ready} !== 2'b01) begin
      errors++;
      $display("FAIL drain: got busy/rdy=%b required 01", {busy, rows_bus.rows_ready});
    end
  endtask

  task automatic test_padding();
    logic [9*PW-1:0] w;
    pack_rows(2);
    win_bus.win_ready   = 1'b0;
    rows_bus.rows_valid = 1'b1;
    @(negedge clk);
    rows_bus.rows_valid = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      w = (ch == 0) ? win_bus.win_R : (ch == 1) ? win_bus.win_G : win_bus.win_B;
      checks++;
      if ({w[7:0], w[31:24], w[55:48]} !== 24'h0 || w !== exp_win(2, ch, 0)) begin
        errors++;
        $display("FAIL pad_left ch%0d: got %h required %h", ch, w, exp_win(2, ch, 0));
      end
    end
    win_bus.win_ready = 1'b1;
    repeat (W - 1) @(negedge clk);
    checks++;
    if (win_bus.win_col !== 9'(W - 1) || win_bus.win_last !== 1'b1) begin
      errors++;
      $display("FAIL pad_reach_last: got col=%0d last=%b required %0d 1",
               win_bus.win_col, win_bus.win_last, W - 1);
    end
    for (int ch = 0; ch < 3; ch++) begin
      w = (ch == 0) ? win_bus.win_R : (ch == 1) ? win_bus.win_G : win_bus.win_B;
      checks++;
      if ({w[23:16], w[47:40], w[71:64]} !== 24'h0 || w !== exp_win(2, ch, W - 1)) begin
        errors++;
        $display("FAIL pad_right ch%0d: got %h required %h", ch, w, exp_win(2, ch, W - 1));
      end
    end
    @(negedge clk);
    win_bus.win_ready = 1'b0;
    checks++;
    if ({win_bus.win_valid, rows_bus.rows_ready} !== 2'b01) begin
      errors++;
      $display("FAIL pad_end_idle: got vld/rdy=%b required 01", {win_bus.win_valid, rows_bus.rows_ready});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_count_last();
    test_backpressure();
    test_no_recapture();
    test_padding();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
